// File: rtl/cpu_ifetch.sv
// cpu_ifetch: single-word Avalon-MM instruction fetch with wait-state
// tolerance, big-endian byte swap and halt on null or misaligned PC.
module cpu_ifetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        fetch_en,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid,
  output logic        pc_wen_o,
  output logic        active_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID,
    HALT
  } state_t;

  state_t state;

  logic pc_halt;
  logic pc_misal;
  logic start;

  assign pc_halt  = (pc_i == HALT_ADDR);
  assign pc_misal = (pc_i[1:0] != 2'b00);

  // pc_i is stale while pc_wen_o is high, so VALID waits one cycle
  assign start = fetch_en &&
                 ((state == IDLE) ||
                  (state == VALID && !pc_wen_o));

  assign avm_byteenable = 4'b1111;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      avm_address <= 32'h0;
      avm_read    <= 1'b0;
      instr_o     <= 32'h0;
      instr_pc_o  <= RESET_VECTOR;
      instr_valid <= 1'b0;
      pc_wen_o    <= 1'b0;
      active_o    <= 1'b1;
      fault_o     <= 1'b0;
    end else begin
      pc_wen_o <= 1'b0;
      unique case (state)
        IDLE, VALID: begin
          if (start) begin
            instr_valid <= 1'b0;
            if (pc_halt) begin
              state    <= HALT;
              active_o <= 1'b0;
            end else if (pc_misal) begin
              state    <= HALT;
              fault_o  <= 1'b1;
              active_o <= 1'b0;
            end else begin
              state       <= REQ;
              avm_address <= pc_i;
              avm_read    <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            instr_o <= {avm_readdata[7:0],
                        avm_readdata[15:8],
                        avm_readdata[23:16],
                        avm_readdata[31:24]};
            instr_pc_o  <= avm_address;
            instr_valid <= 1'b1;
            avm_read    <= 1'b0;
            pc_wen_o    <= 1'b1;
            state       <= VALID;
          end
        end
        HALT: begin
          avm_read    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
